// File: rtl/bgr2gray_binarization.sv
// BMP grayscale + threshold engine: copies a BGR image from ROM into an
// internal dual-port RAM as gray, then binarizes the pixel bytes in place.
// Optional build macro: BIN_INVERT_EN swaps the binarization polarity
// (bytes >= THRESH become 8'h00, all others 8'hFF).
module bgr2gray_binarization #(
    parameter int unsigned IMG_W    = 512,
    parameter int unsigned IMG_H    = 512,
    parameter int unsigned HDR_SIZE = 54,
    parameter int unsigned THRESH   = 128,
    localparam int unsigned TOTAL   = HDR_SIZE + IMG_W * IMG_H * 3,
    localparam int unsigned AW      = $clog2(TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          rom_valid,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [7:0]    dbg_data,
    output logic          gray_done,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, GRAY, BIN, DONE} state_t;

    state_t        r_state;
    // ROM return pipeline: data on rom_data belongs to r_ret_addr when r_ret_vld
    logic          r_ret_vld;
    logic [AW-1:0] r_ret_addr;
    // Pixel assembly: phase 0/1/2 = B/G/R byte of the current triple
    logic [1:0]    r_phase;
    logic [7:0]    r_b;
    logic [7:0]    r_g;
    logic [7:0]    r_y;
    // Remaining gray writes (bytes a+1, a+2) after the R byte arrives
    logic [1:0]    r_wcnt;
    logic [AW-1:0] r_waddr;
    // Binarize walker: phase 0 reads, phase 1 writes back
    logic [AW-1:0] r_baddr;
    logic          r_bphase;

    logic [7:0]    r_mem [TOTAL];
    logic [7:0]    r_rd2;

    logic          w_hdr;
    logic [15:0]   w_sum;
    logic [7:0]    w_y;
    logic          w_we1;
    logic [AW-1:0] w_wa1;
    logic [7:0]    w_wd1;
    logic          w_we2;
    logic [AW-1:0] w_wa2;
    logic [7:0]    w_wd2;
    logic          w_ge;

    // Luma of the triple completing this cycle; max is 256*255 so 16 bits suffice
    assign w_hdr = (r_ret_addr < AW'(HDR_SIZE));
    assign w_sum = (16'd29 * {8'd0, r_b}) + (16'd150 * {8'd0, r_g}) + (16'd77 * {8'd0, rom_data});
    assign w_y   = w_sum[15:8];
    assign w_ge  = (r_rd2 >= 8'(THRESH));
    assign dbg_data = r_rd2;

    // Control FSM, ROM fetch sequencing and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            rom_valid  <= 1'b0;
            rom_addr   <= '0;
            gray_done  <= 1'b0;
            done       <= 1'b0;
            r_ret_vld  <= 1'b0;
            r_ret_addr <= '0;
            r_phase    <= 2'd0;
            r_b        <= 8'd0;
            r_g        <= 8'd0;
            r_y        <= 8'd0;
            r_wcnt     <= 2'd0;
            r_waddr    <= '0;
            r_baddr    <= '0;
            r_bphase   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state   <= GRAY;
                        rom_valid <= 1'b1;
                        rom_addr  <= '0;
                        r_ret_vld <= 1'b0;
                        r_phase   <= 2'd0;
                        r_wcnt    <= 2'd0;
                    end
                end
                GRAY: begin
                    r_ret_vld  <= rom_valid;
                    r_ret_addr <= rom_addr;
                    if (rom_valid) begin
                        if (rom_addr == AW'(TOTAL - 1)) begin
                            rom_valid <= 1'b0;
                        end else begin
                            rom_addr <= rom_addr + AW'(1);
                        end
                    end
                    if (r_wcnt != 2'd0) begin
                        r_wcnt  <= r_wcnt - 2'd1;
                        r_waddr <= r_waddr + AW'(1);
                        if (r_wcnt == 2'd1 && r_waddr == AW'(TOTAL - 1)) begin
                            gray_done <= 1'b1;
                            r_state   <= BIN;
                            r_baddr   <= AW'(HDR_SIZE);
                            r_bphase  <= 1'b0;
                        end
                    end
                    if (r_ret_vld && !w_hdr) begin
                        case (r_phase)
                            2'd0: begin
                                r_b     <= rom_data;
                                r_phase <= 2'd1;
                            end
                            2'd1: begin
                                r_g     <= rom_data;
                                r_phase <= 2'd2;
                            end
                            default: begin
                                r_y     <= w_y;
                                r_waddr <= r_ret_addr - AW'(1);
                                r_wcnt  <= 2'd2;
                                r_phase <= 2'd0;
                            end
                        endcase
                    end
                end
                BIN: begin
                    if (!r_bphase) begin
                        r_bphase <= 1'b1;
                    end else begin
                        r_bphase <= 1'b0;
                        if (r_baddr == AW'(TOTAL - 1)) begin
                            done    <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_baddr <= r_baddr + AW'(1);
                        end
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Port 1 write mux: header copy, first gray byte, then the two trailing gray bytes
    always_comb begin
        w_we1 = 1'b0;
        w_wa1 = '0;
        w_wd1 = 8'd0;
        if (r_state == GRAY) begin
            if (r_ret_vld && w_hdr) begin
                w_we1 = 1'b1;
                w_wa1 = r_ret_addr;
                w_wd1 = rom_data;
            end else if (r_ret_vld && r_phase == 2'd2) begin
                w_we1 = 1'b1;
                w_wa1 = r_ret_addr - AW'(2);
                w_wd1 = w_y;
            end else if (r_wcnt != 2'd0) begin
                w_we1 = 1'b1;
                w_wa1 = r_waddr;
                w_wd1 = r_y;
            end
        end
    end

    // Port 2 mux: readback address when idle/finished, binarize walker otherwise
    always_comb begin
        w_wa2 = r_baddr;
        if (r_state == IDLE || r_state == DONE) begin
            w_wa2 = dbg_addr;
        end
        w_we2 = (r_state == BIN) && r_bphase;
`ifdef BIN_INVERT_EN
        w_wd2 = w_ge ? 8'h00 : 8'hFF;
`else
        w_wd2 = w_ge ? 8'hFF : 8'h00;
`endif
    end

    // Dual-port byte RAM, synchronous write, one-cycle read on port 2
    always_ff @(posedge clk) begin
        if (w_we1) begin
            r_mem[w_wa1] <= w_wd1;
        end
        if (w_we2) begin
            r_mem[w_wa2] <= w_wd2;
        end
        r_rd2 <= r_mem[w_wa2];
    end

endmodule

// File: tb/tb_bgr2gray_binarization.sv
// Randomized scoreboard bench for bgr2gray_binarization on a 4x2 image.
module tb_bgr2gray_binarization;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int HDR  = 54;
    localparam int TH   = 128;
    localparam int T    = HDR + W * H * 3;
    localparam int NPIX = W * H;
    localparam int AW   = $clog2(T);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          rom_valid;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic [AW-1:0] dbg_addr;
    logic [7:0]    dbg_data;
    logic          gray_done;
    logic          done;

    int total = 0;
    int bad   = 0;

    logic [7:0] rom_mem [T];
    int         exp_img [T];
    int         exp_q [$];
    int         addr_q [$];
    logic       rb_req;
    logic       rb_req_d;
    int         rom_next;
    int         rom_cnt;
    int         mon_a;
    int         mon_e;

    bgr2gray_binarization #(
        .IMG_W(W), .IMG_H(H), .HDR_SIZE(HDR), .THRESH(TH)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .rom_valid(rom_valid), .rom_addr(rom_addr), .rom_data(rom_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .gray_done(gray_done), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ROM model: byte appears one cycle after the strobe
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // ROM strobes must walk 0..T-1 once per run
    always @(negedge clk) begin
        if (rst) begin
            rom_next = 0;
            rom_cnt  = 0;
        end else if (rom_valid) begin
            check("rom_addr order", int'(rom_addr), rom_next);
            rom_next++;
            rom_cnt++;
        end
    end

    // Scoreboard monitor: readback data arrives one cycle after the request
    always @(posedge clk) rb_req_d <= rb_req;
    always @(negedge clk) begin
        if (rb_req_d) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL readback: data with empty scoreboard");
            end else begin
                mon_a = addr_q.pop_front();
                mon_e = exp_q.pop_front();
                check($sformatf("ram[%0d]", mon_a), int'(dbg_data), mon_e);
            end
        end
    end

    task automatic fill_img(input int mode);
        for (int a = 0; a < T; a++) rom_mem[a] = 8'($urandom_range(0, 255));
        if (mode == 0) begin
            for (int a = HDR; a < T; a++) rom_mem[a] = 8'd200;
        end else if (mode == 1) begin
            rom_mem[HDR + 0] = 8'd0;   rom_mem[HDR + 1] = 8'd0;   rom_mem[HDR + 2] = 8'd255;
            rom_mem[HDR + 3] = 8'd128; rom_mem[HDR + 4] = 8'd128; rom_mem[HDR + 5] = 8'd128;
            rom_mem[HDR + 6] = 8'd127; rom_mem[HDR + 7] = 8'd127; rom_mem[HDR + 8] = 8'd127;
        end
    endtask

    // Reference image: header verbatim, each pixel -> luma -> threshold
    task automatic build_exp();
        int b, g, r, y, v;
        for (int a = 0; a < HDR; a++) exp_img[a] = int'(rom_mem[a]);
        for (int k = 0; k < NPIX; k++) begin
            b = int'(rom_mem[HDR + 3 * k]);
            g = int'(rom_mem[HDR + 3 * k + 1]);
            r = int'(rom_mem[HDR + 3 * k + 2]);
            y = (29 * b + 150 * g + 77 * r) / 256;
`ifdef BIN_INVERT_EN
            v = (y >= TH) ? 0 : 255;
`else
            v = (y >= TH) ? 255 : 0;
`endif
            for (int j = 0; j < 3; j++) exp_img[HDR + 3 * k + j] = v;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run(input bit hold, input string tag);
        int  cyc;
        bit  got;
        in_valid = 1'b1;
        cyc = 0;
        got = 0;
        while (cyc < 4 * T + 50 && !got) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!hold) in_valid = 1'b0;
            if (gray_done) got = 1;
        end
        check({tag, " gray_done"}, int'(gray_done), 1);
        check({tag, " done low at gray_done"}, int'(done), 0);
        check({tag, " gray latency ok"}, int'(cyc <= 2 * T + 9), 1);
        cyc = 0;
        got = 0;
        while (cyc < 4 * T + 50 && !got) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) got = 1;
        end
        check({tag, " done"}, int'(done), 1);
        check({tag, " bin latency ok"}, int'(cyc <= 2 * (T - HDR) + 9), 1);
        if (hold) begin
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                check({tag, " rom_valid idle after done"}, int'(rom_valid), 0);
                check({tag, " done held"}, int'(done), 1);
                check({tag, " gray_done held"}, int'(gray_done), 1);
            end
        end
        in_valid = 1'b0;
        check({tag, " rom strobe count"}, rom_cnt, T);
    endtask

    task automatic readback();
        for (int a = 0; a < T; a++) begin
            addr_q.push_back(a);
            exp_q.push_back(exp_img[a]);
            dbg_addr = AW'(a);
            rb_req   = 1'b1;
            @(posedge clk);
            #1;
        end
        rb_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rom_valid"}, int'(rom_valid), 0);
        check({tag, " rom_addr"}, int'(rom_addr), 0);
        check({tag, " gray_done"}, int'(gray_done), 0);
        check({tag, " done"}, int'(done), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        dbg_addr = '0;
        rb_req   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle rom_valid", int'(rom_valid), 0);

        // Uniform 200 pixels, threshold corner pixels, then random images
        for (int m = 0; m < 5; m++) begin
            do_reset();
            fill_img(m < 2 ? m : 2);
            build_exp();
            run(1'b0, $sformatf("run%0d", m));
            readback();
        end

        // Reset mid-GRAY aborts; rerun on a fresh image
        do_reset();
        fill_img(2);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid-gray rom_valid active", int'(rom_valid), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("mid-gray reset");
        rst = 1'b0;
        fill_img(1);
        build_exp();
        run(1'b0, "rerun");
        readback();

        // in_valid held high through DONE must not trigger another pass
        do_reset();
        fill_img(2);
        build_exp();
        run(1'b1, "hold");
        readback();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bgr2gray_binarization.md
BGR2GRAY_BINARIZATION -- requirements
Module: bgr2gray_binarization

Interface
REQ-001 SHALL have parameter IMG_W, default 512, image width in pixels; IMG_W*3 must be a multiple of 4, so rows carry no padding.
REQ-002 SHALL have parameter IMG_H, default 512, image height in pixels.
REQ-003 SHALL have parameter HDR_SIZE, default 54, BMP header byte count.
REQ-004 SHALL have parameter THRESH, default 128, binarization threshold (8-bit).
REQ-005 SHALL have derived constants TOTAL = HDR_SIZE + IMG_W*IMG_H*3 and AW = clog2(TOTAL), the address width.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-009 SHALL have port in_valid, input, 1 bit: start request, level-sensitive.
REQ-010 SHALL have port rom_valid, output, 1 bit: ROM read strobe.
REQ-011 SHALL have port rom_addr, output, AW bits: ROM byte address.
REQ-012 SHALL have port rom_data, input, 8 bits: ROM byte, valid one cycle after the rom_valid strobe.
REQ-013 SHALL have port dbg_addr, input, AW bits: readback address.
REQ-014 SHALL have port dbg_data, output, 8 bits: RAM byte at dbg_addr, one-cycle latency.
REQ-015 SHALL have port gray_done, output, 1 bit: grayscale phase complete, held high.
REQ-016 SHALL have port done, output, 1 bit: whole image complete, held high.

Function
REQ-017 SHALL contain an internal dual-port RAM of TOTAL bytes: synchronous write, synchronous read with one-cycle latency; port 1 serves the gray stage, port 2 serves the binarize stage and readback.
REQ-018 SHALL use FSM states IDLE, GRAY, BIN, DONE; IDLE goes to GRAY on the first cycle in_valid=1; in_valid is ignored outside IDLE.
REQ-019 SHALL, in GRAY, read ROM bytes 0..TOTAL-1 in ascending order and copy bytes 0..HDR_SIZE-1 unchanged to the same RAM addresses.
REQ-020 SHALL, in GRAY, treat each pixel triple as B,G,R at address a, a+1, a+2 (a = HDR_SIZE + 3k) and compute Y = (29*B + 150*G + 77*R) >> 8 in a 16-bit unsigned datapath; Y is never above 255 and is written to all three bytes.
REQ-021 SHALL assert gray_done on the cycle after the last pixel write and then enter BIN.
REQ-022 SHALL, in BIN, read each byte HDR_SIZE..TOTAL-1 via port 2 and write back 8'hFF if byte >= THRESH, else 8'h00; header bytes are never modified.
REQ-023 SHALL assert done on the cycle after the last BIN write and then hold DONE; gray_done and done stay high until reset.
REQ-024 SHALL meet latency: GRAY at most 2*TOTAL+8 cycles; BIN at most 2*(TOTAL-HDR_SIZE)+8 cycles.
REQ-025 SHALL drive port 2 from dbg_addr only in IDLE and DONE; RAM contents are undefined before the first completed run.
REQ-026 SHALL keep rom_valid low outside GRAY.

Reset
REQ-027 SHALL, on rst=1 at a rising edge, set the FSM to IDLE, zero all counters, and drive rom_valid=0, rom_addr=0, gray_done=0, done=0.
REQ-028 SHALL, on reset mid-operation, abort the run; RAM contents are not cleared, and a new run restarts from address 0 when in_valid is high.

Configuration
REQ-029 SHALL, with macro BIN_INVERT_EN defined, write 8'h00 for byte >= THRESH and 8'hFF otherwise; with it undefined, follow REQ-022. Header handling and timing are identical in both builds.

Verification
REQ-030 SHALL cover a 4x2 image (TOTAL=78) with all pixels B=G=R=200 -> after done, bytes 54..77 are FF and bytes 0..53 equal the ROM.
REQ-031 SHALL cover one pixel B=0, G=0, R=255 -> Y=76 and binarized to 00 (FF with BIN_INVERT_EN).
REQ-032 SHALL cover pixel bytes 128 and 127 (gray in, B=G=R) -> Y=128 gives FF and Y=127 gives 00, exercising the threshold boundary.
REQ-033 SHALL cover a rst pulse mid-GRAY -> outputs return to reset values next cycle; a rerun completes with correct contents and done=1.
REQ-034 SHALL cover in_valid held high through DONE -> no second run; done stays 1 and the latency bound of REQ-024 holds.
